shift_tx_ctrl: RTL

Sequencer that sits directly upstream of param_shift_reg and turns it into a parallel-to-serial transmitter. It accepts a parallel word on a valid/ready handshake and drives the register's mode and data_in for one load cycle, then for width shift cycles. It samples the register's data_out to present one serial bit per cycle with a valid strobe, and pulses done at frame end.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/param_shift_reg.sv | 38 +++
 rtl/shift_tx_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : shift_pkg                                                   |
// | Desc   : Shared mode, direction and state encodings for the serial   |
// |          transmit controller and its downstream shift register.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package shift_pkg;

    localparam logic [1:0] MODE_STORE = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_RIGHT = 2'b11;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : param_shift_reg                                             |
// | Desc   : Parameterised store/load/left/right shift register; zeroes  |
// |          are shifted in from the vacated end.                        |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module param_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            case (i_mode)
                MODE_LOAD:  r_q <= i_data;
                MODE_LEFT:  r_q <= {r_q[WIDTH-2:0], 1'b0};
                MODE_RIGHT: r_q <= {1'b0, r_q[WIDTH-1:1]};
                default:    r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule : param_shift_reg
`default_nettype wire

// File: rtl/shift_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : shift_tx_ctrl                                               |
// | Desc   : Drives param_shift_reg as a parallel-to-serial transmitter. |
// |          Optional macro SER_STALL_EN adds i_ser_ready backpressure.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module shift_tx_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_dir,
    output logic [1:0]       o_sr_mode,
    output logic [WIDTH-1:0] o_sr_data,
    input  logic [WIDTH-1:0] i_sr_q,
`ifdef SER_STALL_EN
    input  logic             i_ser_ready,
`endif
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_dir;
    logic             w_ser_ready;
    logic             w_advance;
    logic             w_last;
    logic             w_unused;

`ifdef SER_STALL_EN
    assign w_ser_ready = i_ser_ready;
`else
    assign w_ser_ready = 1'b1;
`endif

    assign w_advance = (r_state == ST_SHIFT) && w_ser_ready;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    // Only the two end bits of the register are ever observed.
    assign w_unused  = ^i_sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && i_in_valid) begin
                r_word <= i_in_data;
                r_dir  <= i_in_dir;
                r_cnt  <= '0;
            end else if (w_advance) begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_sr_mode   = MODE_STORE;
        o_ser_out   = 1'b0;
        o_ser_valid = 1'b0;
        o_done      = 1'b0;
        o_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_sr_mode   = MODE_LOAD;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                o_ser_valid = 1'b1;
                o_ser_out   = (r_dir == DIR_LSB_FIRST) ? i_sr_q[0] : i_sr_q[WIDTH-1];
                // A stalled bit keeps the register in store so ser_out stays put.
                if (w_ser_ready) begin
                    o_sr_mode = (r_dir == DIR_LSB_FIRST) ? MODE_RIGHT : MODE_LEFT;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_sr_data = r_word;

endmodule : shift_tx_ctrl
`default_nettype wire
